traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Phase sequencer for a two-road intersection (north-south / east-west) with a pedestrian walk phase. It holds the current phase in a clocked state register, counts each phase's dwell with a down-counter, and decodes the lamp drive outputs. It sits above the flip-flop storage primitives and is the top-level controller of the traffic-light datapath.

## Interface
- GREEN_T, default 8: green dwell in cycles; must be ≥1.
- YELLOW_T, default 3: yellow dwell in cycles; must be ≥1.
- ALLRED_T, default 1: all-red clearance in cycles; must be ≥1.
- WALK_T, default 5: pedestrian walk dwell in cycles; must be ≥1.
- TMR_W, default 8: timer width; every *_T must satisfy *_T-1 < 2^TMR_W.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ped_req  in  1  pedestrian button; level or pulse, sampled every cycle.
- car_ew  in  1  east-west vehicle sensor; 1 = vehicle waiting.
- ns_light  out  3  north-south lamps, one-hot {R,Y,G}: 100 = red, 010 = yellow, 001 = green.
- ew_light  out  3  east-west lamps, same encoding as ns_light.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse when a pending walk request is accepted.
- phase  out  3  current state encoding, for debug.

## Operation
- States: NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, WALK.
- Normal sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→(WALK if ped_pend, else NS_G); WALK→NS_G.
- Lamps:
  - NS_G: ns = green, ew = red.
  - NS_Y: ns = yellow, ew = red.
  - EW_G: ew = green, ns = red.
  - EW_Y: ew = yellow, ns = red.
  - AR1, AR2, WALK: both red.
  - walk = 1 only in WALK.
- Timer: on entry to a state it is loaded with that state's T-1. It decrements each cycle. The state is left in the cycle after the timer reads 0, so every state lasts exactly T cycles.
- NS_G dwell: if the timer reaches 0 while car_ew = 0 and ped_pend = 0, remain in NS_G and reload GREEN_T-1.
- ped_pend register:
  - Next value = ped_req | (ped_pend & ~walk_entry).
  - ped_req asserted in the same cycle as the WALK entry keeps ped_pend set; that request is served on the following round.
  - ped_req during WALK is latched and served on the next round.
- ped_ack: high for exactly the first cycle of WALK.
- Reset (asynchronous): state = AR2, timer = ALLRED_T-1, ped_pend = 0. This gives ns_light = 100, ew_light = 100, walk = 0, ped_ack = 0, phase = AR2.
- Reset asserted mid-phase: all of the above take effect immediately, with no dependence on the clock.
- Outputs are a decode of the registered state and never combinationally depend on any input.

## Timing
- Full cycle with no pedestrian request and car_ew = 1: 2·GREEN_T + 2·YELLOW_T + 2·ALLRED_T cycles. With the defaults: 8+3+1+8+3+1 = 24.
- A WALK round adds WALK_T cycles.
- First NS_G cycle after reset release: cycle ALLRED_T (count starting from the first edge).
- The controller never shows green on both roads or yellow on both roads, in any state, including across reset.

## Configuration
- Macro: EMERG_PREEMPT_EN.
- When defined:
  - Adds input port emerg (1 bit) and state EMERG (both red, walk = 0).
  - emerg = 1 in NS_G or EW_G: the next state is the corresponding yellow, which still runs its full YELLOW_T.
  - After yellow, proceed to the normal all-red state. When that all-red state expires with emerg = 1, go to EMERG.
  - emerg = 1 in any yellow or AR state follows this same path.
  - emerg = 1 in WALK: WALK runs to completion, then go to EMERG.
  - EMERG holds while emerg = 1. On release, go to AR2, with ALLRED_T reloaded.
  - ped_pend is preserved through EMERG.
- When undefined: no emerg port, no EMERG state; behaviour is exactly as above.

## Structure
- Package traffic_pkg:
  - state enum with 3-bit encoding (EMERG included only under the macro);
  - lamp constants LAMP_R, LAMP_Y, LAMP_G.
- Sub-module phase_timer:
  - TMR_W-bit down-counter;
  - inputs: load, load_val;
  - output: zero flag;
  - same clk / rst_n as the controller, resetting to ALLRED_T-1.
- Top-level contents: the state register, the ped_pend flop, next-state logic, and the lamp decode.

## Test plan
- Reset, then release with car_ew = 1 and defaults → NS_G at cycle 1. Full 24-cycle period repeats; lamp sequence and per-state durations of 8/3/1/8/3/1.
- car_ew = 0, no ped_req → NS_G holds indefinitely with the timer reloading. Raise car_ew → NS_Y begins the cycle after the next timer-zero.
- One-cycle ped_req pulse during EW_G → after AR2, enter WALK for 5 cycles, with ped_ack high only on WALK's first cycle; then NS_G.
- ped_req held high through WALK entry → WALK is taken twice on consecutive rounds. Two pulses within one round → WALK is taken only once.
- Assert rst_n low in the middle of EW_Y, off a clock edge → outputs immediately show 100/100 with walk = 0. After release, behaviour is identical to the first test.
- EMERG_PREEMPT_EN: emerg asserted in cycle 2 of NS_G → NS_Y for 3 cycles, AR1 for 1 cycle, then EMERG holds until emerg drops, then AR2 for 1 cycle, then NS_G.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp codes for traffic_light_ctrl.
// The EMERG state exists only when EMERG_PREEMPT_EN is defined.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
`ifdef EMERG_PREEMPT_EN
        ,
        EMERG = 3'd7
`endif
    } state_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request inputs and lamp outputs of traffic_light_ctrl.
// The emerg input is present only when EMERG_PREEMPT_EN is defined.
interface traffic_light_ctrl_if;

    logic       ped_req;
    logic       car_ew;
`ifdef EMERG_PREEMPT_EN
    logic       emerg;
`endif
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
`ifdef EMERG_PREEMPT_EN
        output emerg,
`endif
        output ped_req,
        output car_ew,
        input  ns_light,
        input  ew_light,
        input  walk,
        input  ped_ack,
        input  phase
    );

    modport slave (
`ifdef EMERG_PREEMPT_EN
        input  emerg,
`endif
        input  ped_req,
        input  car_ew,
        output ns_light,
        output ew_light,
        output walk,
        output ped_ack,
        output phase
    );

endinterface

// File: rtl/phase_timer.sv
// Per-phase dwell down-counter; zero_o flags the last cycle of a dwell.
// Resets to the all-red clearance length to match the controller's reset state.
module phase_timer #(
    parameter int unsigned TMR_W    = 8,
    parameter int unsigned ALLRED_T = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = load_i ? load_val_i : cnt_q - TMR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= TMR_W'(ALLRED_T - 1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection phase sequencer with pedestrian walk phase.
// Optional emergency preemption is enabled by defining EMERG_PREEMPT_EN.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 5,
    parameter int unsigned TMR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_light_ctrl_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic             ped_pend_q;
    logic             ped_pend_d;
    logic             ped_ack_q;
    logic             ped_ack_d;
    logic             walk_entry;
    logic             tmr_zero;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;

    phase_timer #(
        .TMR_W    (TMR_W),
        .ALLRED_T (ALLRED_T)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= AR2;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_G: begin
                // Green holds while nobody waits; the timer simply reloads.
                if (tmr_zero && (bus.car_ew || ped_pend_q)) state_d = NS_Y;
`ifdef EMERG_PREEMPT_EN
                if (bus.emerg) state_d = NS_Y;
`endif
            end
            NS_Y: if (tmr_zero) state_d = AR1;
            AR1: begin
                if (tmr_zero) begin
                    state_d = EW_G;
`ifdef EMERG_PREEMPT_EN
                    if (bus.emerg) state_d = EMERG;
`endif
                end
            end
            EW_G: begin
                if (tmr_zero) state_d = EW_Y;
`ifdef EMERG_PREEMPT_EN
                if (bus.emerg) state_d = EW_Y;
`endif
            end
            EW_Y: if (tmr_zero) state_d = AR2;
            AR2: begin
                if (tmr_zero) begin
                    state_d = ped_pend_q ? WALK : NS_G;
`ifdef EMERG_PREEMPT_EN
                    if (bus.emerg) state_d = EMERG;
`endif
                end
            end
            WALK: begin
                if (tmr_zero) begin
                    state_d = NS_G;
`ifdef EMERG_PREEMPT_EN
                    if (bus.emerg) state_d = EMERG;
`endif
                end
            end
`ifdef EMERG_PREEMPT_EN
            EMERG: if (!bus.emerg) state_d = AR2;
`endif
            default: state_d = AR2;
        endcase
    end

    always_comb begin
        case (state_d)
            NS_G, EW_G: tmr_val = TMR_W'(GREEN_T - 1);
            NS_Y, EW_Y: tmr_val = TMR_W'(YELLOW_T - 1);
            WALK:       tmr_val = TMR_W'(WALK_T - 1);
            default:    tmr_val = TMR_W'(ALLRED_T - 1);
        endcase
    end

    // Reload on every phase change (including preemption) and on each green re-dwell.
    assign tmr_load   = tmr_zero || (state_d != state_q);
    assign walk_entry = (state_q == AR2) && (state_d == WALK);
    assign ped_pend_d = bus.ped_req | (ped_pend_q & ~walk_entry);
    assign ped_ack_d  = walk_entry;

    always_comb begin
        bus.ns_light = LAMP_R;
        bus.ew_light = LAMP_R;
        case (state_q)
            NS_G:    bus.ns_light = LAMP_G;
            NS_Y:    bus.ns_light = LAMP_Y;
            EW_G:    bus.ew_light = LAMP_G;
            EW_Y:    bus.ew_light = LAMP_Y;
            default: begin end
        endcase
        bus.walk    = (state_q == WALK);
        bus.ped_ack = ped_ack_q;
        bus.phase   = state_q;
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: per-cycle phase-table model plus
// directed sequences with literal expectations. Emergency test runs under EMERG_PREEMPT_EN.
module tb_traffic_light_ctrl;

    localparam int G = 8;
    localparam int Y = 3;
    localparam int A = 1;
    localparam int W = 5;

    localparam logic [2:0] P_NSG  = 3'd0;
    localparam logic [2:0] P_NSY  = 3'd1;
    localparam logic [2:0] P_AR1  = 3'd2;
    localparam logic [2:0] P_EWG  = 3'd3;
    localparam logic [2:0] P_EWY  = 3'd4;
    localparam logic [2:0] P_AR2  = 3'd5;
    localparam logic [2:0] P_WALK = 3'd6;
    localparam logic [2:0] P_EMG  = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic emerg_drv = 1'b0;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    traffic_light_ctrl_if ifc ();

    traffic_light_ctrl #(
        .GREEN_T  (G),
        .YELLOW_T (Y),
        .ALLRED_T (A),
        .WALK_T   (W),
        .TMR_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

`ifdef EMERG_PREEMPT_EN
    assign ifc.emerg = emerg_drv;
`endif

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [2:0] m_ph;
    logic [2:0] m_nx;
    int         m_el;
    logic       m_pend;
    logic       m_ack;

    function automatic int dur_of(logic [2:0] p);
        case (p)
            P_NSG, P_EWG: return G;
            P_NSY, P_EWY: return Y;
            P_WALK:       return W;
            default:      return A;
        endcase
    endfunction

    function automatic logic [2:0] model_next(logic [2:0] p, int el, logic car, logic pend, logic em);
        bit done;
        done = (el >= dur_of(p) - 1);
        case (p)
            P_NSG:  return (em || (done && (car || pend))) ? P_NSY : P_NSG;
            P_NSY:  return done ? P_AR1 : p;
            P_AR1:  return done ? (em ? P_EMG : P_EWG) : p;
            P_EWG:  return (em || done) ? P_EWY : p;
            P_EWY:  return done ? P_AR2 : p;
            P_AR2:  return done ? (em ? P_EMG : (pend ? P_WALK : P_NSG)) : p;
            P_WALK: return done ? (em ? P_EMG : P_NSG) : p;
            default: return em ? P_EMG : P_AR2;
        endcase
    endfunction

    function automatic logic [2:0] ns_exp(logic [2:0] p);
        if (p == P_NSG) return 3'b001;
        if (p == P_NSY) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ew_exp(logic [2:0] p);
        if (p == P_EWG) return 3'b001;
        if (p == P_EWY) return 3'b010;
        return 3'b100;
    endfunction

    always_comb m_nx = model_next(m_ph, m_el, ifc.car_ew, m_pend, emerg_drv);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= P_AR2;
            m_el   <= 0;
            m_pend <= 1'b0;
            m_ack  <= 1'b0;
        end else begin
            m_ack  <= (m_nx == P_WALK) && (m_ph != P_WALK);
            m_pend <= ifc.ped_req | (m_pend & !((m_nx == P_WALK) && (m_ph != P_WALK)));
            m_el   <= ((m_nx != m_ph) || (m_el >= dur_of(m_ph) - 1)) ? 0 : m_el + 1;
            m_ph   <= m_nx;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ns_light", int'(ifc.ns_light), int'(ns_exp(m_ph)));
            chk("model_ew_light", int'(ifc.ew_light), int'(ew_exp(m_ph)));
            chk("model_walk",     int'(ifc.walk),     int'(m_ph == P_WALK));
            chk("model_ped_ack",  int'(ifc.ped_ack),  int'(m_ack));
            chk("model_phase",    int'(ifc.phase),    int'(m_ph));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input logic [2:0] p, input string name);
        int n;
        n = 0;
        while (ifc.phase != p && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_%s actual=timeout required=phase %0d", name, p);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ns"},    int'(ifc.ns_light), 4);
        chk({tag, "_ew"},    int'(ifc.ew_light), 4);
        chk({tag, "_walk"},  int'(ifc.walk), 0);
        chk({tag, "_ack"},   int'(ifc.ped_ack), 0);
        chk({tag, "_phase"}, int'(ifc.phase), int'(P_AR2));
    endtask

    // Called at a negedge with rst_n low; releases reset and checks a 48-cycle run.
    task automatic period_run(input string tag);
        logic [2:0] lg [48];
        chk_reset_outputs({tag, "_rst"});
        rst_n = 1'b1;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            lg[k] = ifc.phase;
        end
        chk({tag, "_c1_nsg"},    int'(lg[0]),  int'(P_NSG));
        chk({tag, "_c8_nsg"},    int'(lg[7]),  int'(P_NSG));
        chk({tag, "_c9_nsy"},    int'(lg[8]),  int'(P_NSY));
        chk({tag, "_c11_nsy"},   int'(lg[10]), int'(P_NSY));
        chk({tag, "_c12_ar1"},   int'(lg[11]), int'(P_AR1));
        chk({tag, "_c13_ewg"},   int'(lg[12]), int'(P_EWG));
        chk({tag, "_c20_ewg"},   int'(lg[19]), int'(P_EWG));
        chk({tag, "_c21_ewy"},   int'(lg[20]), int'(P_EWY));
        chk({tag, "_c24_ar2"},   int'(lg[23]), int'(P_AR2));
        chk({tag, "_c25_nsg"},   int'(lg[24]), int'(P_NSG));
        chk({tag, "_c48_ar2"},   int'(lg[47]), int'(P_AR2));
    endtask

    initial begin
        ifc.ped_req = 1'b0;
        ifc.car_ew  = 1'b1;
        step(3);
        chk_en = 1'b1;

        // Reset release and two full 24-cycle periods.
        period_run("p1");

        // No east-west traffic: NS green holds across several dwells.
        wait_phase(P_AR2, "hold_ar2");
        ifc.car_ew = 1'b0;
        wait_phase(P_NSG, "hold_nsg");
        step(32);
        chk("hold_still_nsg", int'(ifc.phase), int'(P_NSG));
        ifc.car_ew = 1'b1;
        step(7);
        chk("hold_last_nsg", int'(ifc.phase), int'(P_NSG));
        step(1);
        chk("hold_then_nsy", int'(ifc.phase), int'(P_NSY));

        // Single pedestrian pulse during EW green.
        wait_phase(P_EWG, "ped1_ewg");
        step(2);
        ifc.ped_req = 1'b1;
        step(1);
        ifc.ped_req = 1'b0;
        wait_phase(P_AR2, "ped1_ar2");
        step(1);
        chk("ped1_walk0", int'(ifc.phase), int'(P_WALK));
        chk("ped1_ack0",  int'(ifc.ped_ack), 1);
        chk("ped1_wlamp", int'(ifc.walk), 1);
        step(1);
        chk("ped1_walk1", int'(ifc.phase), int'(P_WALK));
        chk("ped1_ack1",  int'(ifc.ped_ack), 0);
        step(3);
        chk("ped1_walk4", int'(ifc.phase), int'(P_WALK));
        step(1);
        chk("ped1_nsg",   int'(ifc.phase), int'(P_NSG));

        // Request held through WALK entry: served again on the next round.
        wait_phase(P_EWG, "ped2_ewg");
        ifc.ped_req = 1'b1;
        wait_phase(P_WALK, "ped2_walk");
        step(1);
        ifc.ped_req = 1'b0;
        wait_phase(P_AR2, "ped2_ar2");
        step(1);
        chk("ped2_walk_again", int'(ifc.phase), int'(P_WALK));
        chk("ped2_ack_again",  int'(ifc.ped_ack), 1);

        // Two pulses in one round: a single WALK.
        wait_phase(P_NSG, "ped3_nsg");
        step(2);
        ifc.ped_req = 1'b1;
        step(1);
        ifc.ped_req = 1'b0;
        wait_phase(P_EWG, "ped3_ewg");
        ifc.ped_req = 1'b1;
        step(1);
        ifc.ped_req = 1'b0;
        wait_phase(P_AR2, "ped3_ar2");
        step(1);
        chk("ped3_walk_once", int'(ifc.phase), int'(P_WALK));
        wait_phase(P_NSG, "ped3_nsg2");
        wait_phase(P_AR2, "ped3_ar2b");
        step(1);
        chk("ped3_no_second", int'(ifc.phase), int'(P_NSG));

        // Asynchronous reset mid EW yellow, away from any clock edge.
        wait_phase(P_EWY, "rst_ewy");
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        step(2);
        period_run("p2");

`ifdef EMERG_PREEMPT_EN
        wait_phase(P_NSG, "em_nsg");
        step(1);
        emerg_drv = 1'b1;
        step(1);
        chk("em_nsy0", int'(ifc.phase), int'(P_NSY));
        step(2);
        chk("em_nsy2", int'(ifc.phase), int'(P_NSY));
        step(1);
        chk("em_ar1",  int'(ifc.phase), int'(P_AR1));
        step(1);
        chk("em_emg0", int'(ifc.phase), int'(P_EMG));
        chk("em_ns_r", int'(ifc.ns_light), 4);
        step(4);
        chk("em_emg4", int'(ifc.phase), int'(P_EMG));
        emerg_drv = 1'b0;
        step(1);
        chk("em_ar2",  int'(ifc.phase), int'(P_AR2));
        step(1);
        chk("em_nsg",  int'(ifc.phase), int'(P_NSG));
`endif

        step(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
